// File: rtl/rect_fill_if.sv
// Pixel-fill request/parameter bus and pixel output bus for rect_fill_engine.
// The master side is the drawing FSM plus the downstream sink that drives ready.
interface rect_fill_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           start;
  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic [X_W-1:0] width;
  logic [Y_W-1:0] height;
  logic [2:0]     colour;
  logic           col_major;
  logic           ready;
  logic           busy;
  logic           done;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;

  modport master (
    output start, x0, y0, width, height, colour, col_major, ready,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, x0, y0, width, height, colour, col_major, ready,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Clipped rectangle fill engine: one pixel per accepted cycle, row- or column-major,
// with ready back-pressure and a level start / done handshake.
//
// state  | meaning
// IDLE   | waiting for start; request fields latched on start
// LOAD   | clip rectangle against the screen, detect empty rect
// PLOT   | vga_plot high; coordinates step on vga_plot && ready
// DONE   | done high until start is seen low
module rect_fill_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic        clk,
  input logic        rst,
  rect_fill_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLOT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [X_W:0] SW    = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH    = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
  localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);

  state_t state, state_nxt;

  logic [X_W-1:0] x0_q, w_q, x_q;
  logic [Y_W-1:0] y0_q, h_q, y_q;
  logic [2:0]     colour_q;
  logic           cm_q;
  logic [X_W:0]   x_end_q;
  logic [Y_W:0]   y_end_q;

  logic [X_W:0]   x_sum, x_lim, x_nxt;
  logic [Y_W:0]   y_sum, y_lim, y_nxt;
  logic           empty, last_x, last_y, xfer;

  // Sums are one bit wider so x0+width never wraps before clipping.
  assign x_sum  = {1'b0, x0_q} + {1'b0, w_q};
  assign y_sum  = {1'b0, y0_q} + {1'b0, h_q};
  assign x_lim  = (x_sum > SW) ? SW : x_sum;
  assign y_lim  = (y_sum > SH) ? SH : y_sum;
  assign empty  = (w_q == '0) || (h_q == '0) ||
                  ({1'b0, x0_q} >= SW) || ({1'b0, y0_q} >= SH);

  assign x_nxt  = {1'b0, x_q} + X_ONE;
  assign y_nxt  = {1'b0, y_q} + Y_ONE;
  assign last_x = (x_nxt == x_end_q);
  assign last_y = (y_nxt == y_end_q);
  assign xfer   = (state == S_PLOT) && bus.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.vga_plot   = 1'b0;
    bus.vga_colour = 3'd0;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_LOAD;
      S_LOAD: begin
        bus.busy  = 1'b1;
        state_nxt = empty ? S_DONE : S_PLOT;
      end
      S_PLOT: begin
        bus.busy       = 1'b1;
        bus.vga_plot   = 1'b1;
        bus.vga_colour = colour_q;
        if (xfer && last_x && last_y) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (!bus.start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
      cm_q     <= 1'b0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          x0_q     <= bus.x0;
          y0_q     <= bus.y0;
          w_q      <= bus.width;
          h_q      <= bus.height;
          colour_q <= bus.colour;
          cm_q     <= bus.col_major;
        end
        S_LOAD: begin
          x_end_q <= x_lim;
          y_end_q <= y_lim;
          if (!empty) begin
            x_q <= x0_q;
            y_q <= y0_q;
          end
        end
        S_PLOT: begin
          // The final pixel leaves the coordinates on it for the DONE state.
          if (xfer && !(last_x && last_y)) begin
            if (!cm_q) begin
              if (last_x) begin
                x_q <= x0_q;
                y_q <= y_nxt[Y_W-1:0];
              end else begin
                x_q <= x_nxt[X_W-1:0];
              end
            end else begin
              if (last_y) begin
                y_q <= y0_q;
                x_q <= x_nxt[X_W-1:0];
              end else begin
                y_q <= y_nxt[Y_W-1:0];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vga_x = x_q;
  assign bus.vga_y = y_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: vector table of rectangles checked pixel by
// pixel against a scan-order model, plus reset and done-handshake sequences.
module tb_rect_fill_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rect_fill_if #(.X_W(8), .Y_W(7)) bus ();

  rect_fill_engine #(.X_W(8), .Y_W(7), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] col;
    logic       cm;
    logic       toggle;
    int         exp_n;
    int         lx;
    int         ly;
  } vec_t;

  typedef struct {
    int x;
    int y;
  } pix_t;

  int   checks   = 0;
  int   failures = 0;
  pix_t expq[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic build_model(input vec_t v);
    int xe, ye;
    pix_t p;
    expq.delete();
    xe = (int'(v.x0) + int'(v.w) > 160) ? 160 : int'(v.x0) + int'(v.w);
    ye = (int'(v.y0) + int'(v.h) > 120) ? 120 : int'(v.y0) + int'(v.h);
    if (v.w == 0 || v.h == 0 || v.x0 >= 160 || v.y0 >= 120) return;
    if (v.cm) begin
      for (int x = int'(v.x0); x < xe; x++)
        for (int y = int'(v.y0); y < ye; y++) begin
          p.x = x; p.y = y; expq.push_back(p);
        end
    end else begin
      for (int y = int'(v.y0); y < ye; y++)
        for (int x = int'(v.x0); x < xe; x++) begin
          p.x = x; p.y = y; expq.push_back(p);
        end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc, pc, nxfer, first_plot, done_cyc, last_cyc, lx, ly, px, py;
    logic r, prev_hold;
    pix_t p;
    build_model(v);
    cyc = 0; pc = 0; nxfer = 0; first_plot = -1; done_cyc = -1; last_cyc = -1;
    lx = -1; ly = -1; px = 0; py = 0; prev_hold = 1'b0;
    @(negedge clk);
    bus.x0 = v.x0; bus.y0 = v.y0; bus.width = v.w; bus.height = v.h;
    bus.colour = v.col; bus.col_major = v.cm; bus.ready = 1'b1;
    bus.start = 1'b1;
    while (cyc < 25000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("load_busy", bus.busy, 1);
        chk("load_noplot", bus.vga_plot, 0);
        bus.x0 = 8'($urandom); bus.y0 = 7'($urandom);
        bus.width = 8'($urandom); bus.height = 7'($urandom);
        bus.colour = 3'($urandom); bus.col_major = ~v.cm;
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.vga_plot) begin
        if (first_plot < 0) first_plot = cyc;
        if (prev_hold) begin
          chk("hold_x", bus.vga_x, px);
          chk("hold_y", bus.vga_y, py);
        end
        chk("plot_colour", bus.vga_colour, v.col);
        r = v.toggle ? ((pc % 3) == 0) : 1'b1;
        pc++;
        bus.ready = r;
        if (r) begin
          if (expq.size() == 0) begin
            chk("extra_pixel", nxfer, v.exp_n);
          end else begin
            p = expq.pop_front();
            chk("pix_x", bus.vga_x, p.x);
            chk("pix_y", bus.vga_y, p.y);
          end
          nxfer++;
          lx = int'(bus.vga_x); ly = int'(bus.vga_y); last_cyc = cyc;
        end
        prev_hold = !r;
        px = int'(bus.vga_x); py = int'(bus.vga_y);
      end
    end
    chk("done_seen", (done_cyc > 0), 1);
    chk("pixel_count", nxfer, v.exp_n);
    chk("model_drained", expq.size(), 0);
    if (v.exp_n > 0) begin
      chk("first_plot_cycle", first_plot, 2);
      chk("done_after_last", done_cyc, last_cyc + 1);
      chk("last_x", lx, v.lx);
      chk("last_y", ly, v.ly);
    end else begin
      chk("empty_done_cycle", done_cyc, 2);
    end
    chk("done_busy", bus.busy, 0);
    chk("done_colour", bus.vga_colour, 0);
    repeat (3) begin
      @(negedge clk);
      chk("done_held", bus.done, 1);
      chk("done_noplot", bus.vga_plot, 0);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_fall", bus.done, 0);
    @(negedge clk);
    chk("idle_done", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_plot", bus.vga_plot, 0);
    bus.ready = 1'b1;
  endtask

  initial begin
    //         x0     y0    w      h     col   cm    tog   n      lx   ly
    vecs[0] = '{8'd0,   7'd0,   8'd160, 7'd120, 3'd5, 1'b1, 1'b0, 19200, 159, 119};
    vecs[1] = '{8'd10,  7'd5,   8'd3,   7'd2,   3'd3, 1'b0, 1'b0, 6,     12,  6};
    vecs[2] = '{8'd158, 7'd119, 8'd10,  7'd5,   3'd7, 1'b0, 1'b0, 2,     159, 119};
    vecs[3] = '{8'd10,  7'd5,   8'd0,   7'd2,   3'd1, 1'b0, 1'b0, 0,     0,   0};
    vecs[4] = '{8'd200, 7'd5,   8'd3,   7'd2,   3'd1, 1'b0, 1'b0, 0,     0,   0};
    vecs[5] = '{8'd10,  7'd5,   8'd3,   7'd2,   3'd6, 1'b0, 1'b1, 6,     12,  6};
    vecs[6] = '{8'd3,   7'd4,   8'd2,   7'd3,   3'd2, 1'b1, 1'b0, 6,     4,   6};
    vecs[7] = '{8'd5,   7'd120, 8'd4,   7'd1,   3'd4, 1'b0, 1'b0, 0,     0,   0};
    vecs[8] = '{8'd150, 7'd110, 8'd255, 7'd127, 3'd1, 1'b0, 1'b0, 100,   159, 119};

    rst = 1'b1;
    bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.width = '0; bus.height = '0;
    bus.colour = '0; bus.col_major = 1'b0; bus.ready = 1'b1;
    #12;
    chk("rst_plot", bus.vga_plot, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_x", bus.vga_x, 0);
    chk("rst_y", bus.vga_y, 0);
    chk("rst_colour", bus.vga_colour, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of a full-screen fill.
    @(negedge clk);
    bus.x0 = 8'd0; bus.y0 = 7'd0; bus.width = 8'd160; bus.height = 7'd120;
    bus.colour = 3'd5; bus.col_major = 1'b1; bus.ready = 1'b1; bus.start = 1'b1;
    repeat (50) @(negedge clk);
    chk("mid_plotting", bus.vga_plot, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_plot", bus.vga_plot, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_done", bus.done, 0);
    chk("async_rst_x", bus.vga_x, 0);
    chk("async_rst_y", bus.vga_y, 0);
    chk("async_rst_colour", bus.vga_colour, 0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_plot", bus.vga_plot, 0);
      chk("post_rst_busy", bus.busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
